rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
- Reset controller in the always-on CLK domain.
- Releases NUM_DOMAINS domain resets in a fixed ascending order, with a programmable gap between releases.
- Accepts software-requested re-reset of a selected subset of domains, with an acknowledge handshake.
- Outputs drive the per-domain reset synchronizers, which provide async assert and sync deassert in each destination clock.

Parameters:
- NUM_DOMAINS, 3, number of sequenced domain resets (1..8).
- CNT_WIDTH, 8, width of the internal delay counter.
- MIN_ASSERT, 8, cycles every targeted domain is held in reset before the first release (1..2^CNT_WIDTH-1).
- RELEASE_GAP, 16, cycles between consecutive domain releases (1..2^CNT_WIDTH-1).

Ports:
- CLK  in  1  sequencer clock, always running.
- RST  in  1  asynchronous, active-low reset.
- SW_RST_REQ  in  1  software reset request; rising-edge detected in CLK.
- SW_RST_MASK  in  NUM_DOMAINS  domains targeted by the request; sampled with the accepted request edge.
- DOM_RST_N  out  NUM_DOMAINS  per-domain active-low reset; bit 0 is released first.
- SW_RST_ACK  out  1  one-cycle pulse when a request is accepted.
- SEQ_BUSY  out  1  high while a sequence is in progress.
- SEQ_DONE  out  1  high when all domains are released and the block is idle.

Behaviour:
- Reset (RST=0), applied asynchronously and also mid-operation:
  - DOM_RST_N=0 on all bits, SEQ_BUSY=1, SEQ_DONE=0, SW_RST_ACK=0.
  - State ASSERT, cnt=0, target mask = all ones, request edge detector cleared.
- States: ASSERT, GAP, RUN. All outputs are registered.
- ASSERT:
  - cnt increments every edge.
  - At the edge where cnt==MIN_ASSERT-1, release the lowest-index targeted domain, clear cnt and go to GAP.
  - If only one domain is targeted, go to RUN instead.
- GAP:
  - cnt increments every edge.
  - At the edge where cnt==RELEASE_GAP-1, release the next-higher targeted domain and clear cnt.
  - Non-targeted domains are skipped with no gap consumed.
  - After the last targeted domain is released, go to RUN.
- Edge counting: edge 1 is the first CLK rising edge with RST high. The k-th targeted domain (k=0,1,...) rises at edge MIN_ASSERT + k*RELEASE_GAP. With defaults: edges 8, 24, 40.
- Entering RUN: SEQ_BUSY falls and SEQ_DONE rises on the same edge as the last release.
- RUN, rising edge of SW_RST_REQ (REQ=1, previous sample 0) with SW_RST_MASK≠0:
  - Next edge: SW_RST_ACK=1 for exactly one cycle.
  - Targeted DOM_RST_N bits go 0; non-targeted bits stay 1.
  - Mask is latched; SEQ_BUSY=1, SEQ_DONE=0, cnt=0, state ASSERT.
  - Release timing then matches power-on, counted from the ACK edge as edge 0.
- RUN, SW_RST_MASK==0 with a request edge: SW_RST_ACK pulses; no other change.
- Request edges during ASSERT or GAP are ignored: no ACK, not queued. The edge detector still tracks REQ, so a request held high across the end of a sequence does not re-trigger.
- Released domains stay released during a sequence. Only targeted domains are ever re-asserted.
- cnt never exceeds max(MIN_ASSERT, RELEASE_GAP)-1. No wrap-around.

Decomposition:
- Package rst_seq_pkg: state enum (ASSERT, GAP, RUN) and a function returning the next targeted index above a given index.
- No sub-module. The counter and priority-next-index logic stay inline.

Test Plan:
- Power-on, defaults: deassert RST → DOM_RST_N bits 0/1/2 rise at edges 8/24/40; SEQ_DONE=1, SEQ_BUSY=0 at edge 40.
- RUN, REQ rising edge with MASK=3'b101 → ACK pulses 1 cycle; bits 0 and 2 low, bit 1 stays high; bit 0 rises 8 edges after ACK, bit 2 rises 24 edges after ACK.
- RUN, REQ edge with MASK=3'b000 → single ACK pulse; DOM_RST_N stays 3'b111; SEQ_DONE stays 1.
- REQ edge at edge 20 of the power-on sequence → no ACK; releases still at 24/40; REQ held high afterwards → no ACK in RUN.
- RST pulled low at edge 30 (bits 0,1 released) → all outputs return to reset values immediately; re-release restarts from edge 1.
- NUM_DOMAINS=1, MIN_ASSERT=1 → DOM_RST_N rises at edge 1; SEQ_DONE rises on the same edge.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Contents: FSM state enum, "no target" marker, next-targeted-domain search.
// Domain indices are carried as 4 bits so that 8 can stand for "none left".
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_GAP    = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int         MAX_DOMAINS = 8;
  localparam logic [3:0] NO_TGT      = 4'd8;

  // Lowest set bit of mask at or above start; NO_TGT when there is none.
  function automatic logic [3:0] next_tgt(input logic [MAX_DOMAINS-1:0] mask,
                                          input logic [3:0]             start);
    logic [3:0] r;
    r = NO_TGT;
    for (int i = MAX_DOMAINS - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= start)) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Software-request and domain-reset bundle of the reset sequencer.
// master: requester side (drives REQ/MASK, observes ACK and status).
// slave : sequencer side (drives DOM_RST_N, ACK, BUSY, DONE).
interface rst_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   SW_RST_REQ;
  logic [NUM_DOMAINS-1:0] SW_RST_MASK;
  logic                   SW_RST_ACK;
  logic [NUM_DOMAINS-1:0] DOM_RST_N;
  logic                   SEQ_BUSY;
  logic                   SEQ_DONE;

  modport master (
    output SW_RST_REQ, SW_RST_MASK,
    input  SW_RST_ACK, DOM_RST_N, SEQ_BUSY, SEQ_DONE
  );

  modport slave (
    input  SW_RST_REQ, SW_RST_MASK,
    output SW_RST_ACK, DOM_RST_N, SEQ_BUSY, SEQ_DONE
  );
endinterface

// File: rtl/rst_sequencer.sv
// Always-on reset sequencer: releases domain resets in ascending order with a
// fixed hold time and inter-release gap; services software re-reset requests.
// Ports: CLK, RST (async active-low), bus (slave modport: REQ/MASK in; DOM_RST_N,
// ACK, BUSY, DONE out). All outputs are registered.
module rst_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_WIDTH   = 8,
  parameter int MIN_ASSERT  = 8,
  parameter int RELEASE_GAP = 16
) (
  input  logic            CLK,
  input  logic            RST,
  rst_sequencer_if.slave  bus
);
  import rst_seq_pkg::*;

  localparam logic [CNT_WIDTH-1:0] ASSERT_LAST = CNT_WIDTH'(MIN_ASSERT - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(RELEASE_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [NUM_DOMAINS-1:0] mask_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic [3:0]             idx_q;   // next domain to release
  logic                   busy_q;
  logic                   done_q;
  logic                   ack_q;
  logic                   req_q;   // previous REQ sample for edge detect

  logic                   req_edge;
  logic                   cnt_last;
  logic [3:0]             idx_d;    // targeted domain after idx_q
  logic [3:0]             first_d;  // first targeted domain of a new request
  logic [NUM_DOMAINS-1:0] rel_vec;  // one-hot of idx_q

  always_comb begin
    req_edge = bus.SW_RST_REQ & ~req_q;
    cnt_last = (state_q == ST_ASSERT) ? (cnt_q == ASSERT_LAST) : (cnt_q == GAP_LAST);
    // Skipping non-targeted domains happens here: the search jumps straight
    // to the next set mask bit, so no gap is spent on untargeted ones.
    idx_d    = next_tgt(8'(mask_q), idx_q + 4'd1);
    first_d  = next_tgt(8'(bus.SW_RST_MASK), 4'd0);
    rel_vec  = '0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      rel_vec[d] = (idx_q == 4'(d));
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      mask_q  <= '1;
      dom_q   <= '0;
      idx_q   <= 4'd0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      // Edge detector keeps tracking while busy so a request held high
      // across the end of a sequence does not fire once RUN is reached.
      req_q <= bus.SW_RST_REQ;
      ack_q <= 1'b0;
      case (state_q)
        ST_ASSERT, ST_GAP: begin
          if (cnt_last) begin
            dom_q <= dom_q | rel_vec;
            cnt_q <= '0;
            if (idx_d == NO_TGT) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_GAP;
              idx_q   <= idx_d;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (req_edge) begin
            ack_q <= 1'b1;
            if (|bus.SW_RST_MASK) begin
              dom_q   <= dom_q & ~bus.SW_RST_MASK;
              mask_q  <= bus.SW_RST_MASK;
              idx_q   <= first_d;
              cnt_q   <= '0;
              state_q <= ST_ASSERT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_ASSERT;
      endcase
    end
  end

  assign bus.DOM_RST_N  = dom_q;
  assign bus.SW_RST_ACK = ack_q;
  assign bus.SEQ_BUSY   = busy_q;
  assign bus.SEQ_DONE   = done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default-parameter instance checked every cycle
// against a release-schedule model, plus a 1-domain/MIN_ASSERT=1 instance
// checked with literal expectations.
module tb_rst_sequencer;

  localparam int ND = 3;
  localparam int MA = 8;
  localparam int RG = 16;

  logic CLK  = 1'b0;
  logic RST  = 1'b0;
  logic RST2 = 1'b0;

  always #5 CLK = ~CLK;

  rst_sequencer_if #(.NUM_DOMAINS(ND)) bus ();
  rst_sequencer_if #(.NUM_DOMAINS(1))  bus2 ();

  rst_sequencer #(.NUM_DOMAINS(ND), .CNT_WIDTH(8), .MIN_ASSERT(MA), .RELEASE_GAP(RG)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  rst_sequencer #(.NUM_DOMAINS(1), .CNT_WIDTH(8), .MIN_ASSERT(1), .RELEASE_GAP(16)) dut2 (
    .CLK (CLK),
    .RST (RST2),
    .bus (bus2.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int ecnt = 0;   // rising edges since RST was last released

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t edge=%0d)", nm, act, exp, $time, ecnt);
    end
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) ecnt = 0;
    else      ecnt = ecnt + 1;
  end

  // ---------------- behavioural model ----------------
  // A sequence is a table of absolute release edges: the k-th targeted domain
  // releases MA + k*RG edges after the sequence start.
  logic [ND-1:0] m_dom;
  bit m_busy, m_done, m_ack, m_req_prev, m_active;
  int m_cyc, m_last;
  int m_sched[ND];

  task automatic m_start(input logic [ND-1:0] msk);
    int k;
    k = 0;
    for (int d = 0; d < ND; d++) begin
      if (msk[d]) begin
        m_sched[d] = MA + k * RG;
        m_last     = m_sched[d];
        k++;
      end else begin
        m_sched[d] = -1;
      end
    end
    m_cyc    = 0;
    m_active = 1'b1;
    m_busy   = 1'b1;
    m_done   = 1'b0;
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_dom      = '0;
      m_ack      = 1'b0;
      m_req_prev = 1'b0;
      m_start('1);
    end else begin
      m_ack = 1'b0;
      if (m_active) begin
        m_cyc++;
        for (int d = 0; d < ND; d++) if (m_sched[d] == m_cyc) m_dom[d] = 1'b1;
        if (m_cyc == m_last) begin
          m_active = 1'b0;
          m_busy   = 1'b0;
          m_done   = 1'b1;
        end
      end else if (bus.SW_RST_REQ && !m_req_prev) begin
        m_ack = 1'b1;
        if (bus.SW_RST_MASK != '0) begin
          m_dom = m_dom & ~bus.SW_RST_MASK;
          m_start(bus.SW_RST_MASK);
        end
      end
      m_req_prev = bus.SW_RST_REQ;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("dom_rst_n", 8'(bus.DOM_RST_N),  8'(m_dom));
      chk("sw_rst_ack", 8'(bus.SW_RST_ACK), 8'(m_ack));
      chk("seq_busy",  8'(bus.SEQ_BUSY),   8'(m_busy));
      chk("seq_done",  8'(bus.SEQ_DONE),   8'(m_done));
    end
  end

  // Park at the negedge following rising edge n (edge count since release).
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (ecnt < n && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    if (ecnt != n) begin
      n_bad++;
      n_cmp++;
      $display("FAIL wait_edge: reached edge %0d want %0d", ecnt, n);
    end
  endtask

  task automatic lit(input string nm, input logic [ND-1:0] dom, input bit ack,
                     input bit busy, input bit done);
    chk({nm, "_dom"},  8'(bus.DOM_RST_N),  8'(dom));
    chk({nm, "_ack"},  8'(bus.SW_RST_ACK), 8'(ack));
    chk({nm, "_busy"}, 8'(bus.SEQ_BUSY),   8'(busy));
    chk({nm, "_done"}, 8'(bus.SEQ_DONE),   8'(done));
  endtask

  int a;

  initial begin
    bus.SW_RST_REQ   = 1'b0;
    bus.SW_RST_MASK  = '0;
    bus2.SW_RST_REQ  = 1'b0;
    bus2.SW_RST_MASK = '0;

    // Reset state
    @(negedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    lit("reset", 3'b000, 1'b0, 1'b1, 1'b0);

    // Power-on; a request edge at edge 20 must be ignored, and REQ held high
    // into RUN must not fire.
    #1 RST = 1'b1;
    wait_edge(7);  lit("pon_e7",  3'b000, 1'b0, 1'b1, 1'b0);
    wait_edge(8);  lit("pon_e8",  3'b001, 1'b0, 1'b1, 1'b0);
    wait_edge(19);
    #1 bus.SW_RST_REQ = 1'b1; bus.SW_RST_MASK = 3'b111;
    wait_edge(20); lit("pon_e20", 3'b001, 1'b0, 1'b1, 1'b0);
    wait_edge(23); lit("pon_e23", 3'b001, 1'b0, 1'b1, 1'b0);
    wait_edge(24); lit("pon_e24", 3'b011, 1'b0, 1'b1, 1'b0);
    wait_edge(39); lit("pon_e39", 3'b011, 1'b0, 1'b1, 1'b0);
    wait_edge(40); lit("pon_e40", 3'b111, 1'b0, 1'b0, 1'b1);
    wait_edge(46); lit("held",    3'b111, 1'b0, 1'b0, 1'b1);

    // Software re-reset of domains 0 and 2
    #1 bus.SW_RST_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    a = ecnt + 1;
    #1 bus.SW_RST_REQ = 1'b1; bus.SW_RST_MASK = 3'b101;
    wait_edge(a);      lit("m101_ack", 3'b010, 1'b1, 1'b1, 1'b0);
    wait_edge(a + 1);  lit("m101_a1",  3'b010, 1'b0, 1'b1, 1'b0);
    wait_edge(a + 7);  lit("m101_a7",  3'b010, 1'b0, 1'b1, 1'b0);
    wait_edge(a + 8);  lit("m101_a8",  3'b011, 1'b0, 1'b1, 1'b0);
    wait_edge(a + 23); lit("m101_a23", 3'b011, 1'b0, 1'b1, 1'b0);
    wait_edge(a + 24); lit("m101_a24", 3'b111, 1'b0, 1'b0, 1'b1);

    // Empty mask: acknowledge only
    #1 bus.SW_RST_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    a = ecnt + 1;
    #1 bus.SW_RST_REQ = 1'b1; bus.SW_RST_MASK = 3'b000;
    wait_edge(a);      lit("m000_ack", 3'b111, 1'b1, 1'b0, 1'b1);
    wait_edge(a + 1);  lit("m000_a1",  3'b111, 1'b0, 1'b0, 1'b1);

    // Reset pulled mid-sequence at edge 30
    #1 bus.SW_RST_REQ = 1'b0; RST = 1'b0;
    @(negedge CLK);
    #1 RST = 1'b1;
    wait_edge(30); lit("mid_e30", 3'b011, 1'b0, 1'b1, 1'b0);
    #2 RST = 1'b0;
    #1 lit("mid_async", 3'b000, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    #1 RST = 1'b1;
    wait_edge(7);  lit("restart_e7", 3'b000, 1'b0, 1'b1, 1'b0);
    wait_edge(8);  lit("restart_e8", 3'b001, 1'b0, 1'b1, 1'b0);

    // Randomised requests, masks and occasional asynchronous resets
    for (int it = 0; it < 3000; it++) begin
      int r;
      @(negedge CLK);
      #1;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        bus.SW_RST_REQ  = ~bus.SW_RST_REQ;
        bus.SW_RST_MASK = ND'($urandom_range(0, 7));
      end else if (r == 99 && $urandom_range(0, 3) == 0) begin
        #2 RST = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        #1 RST = 1'b1;
      end
    end

    // Single domain, MIN_ASSERT=1
    @(negedge CLK);
    chk("d1_reset_dom",  8'(bus2.DOM_RST_N), 8'h00);
    chk("d1_reset_busy", 8'(bus2.SEQ_BUSY),  8'h01);
    chk("d1_reset_done", 8'(bus2.SEQ_DONE),  8'h00);
    #1 RST2 = 1'b1;
    @(negedge CLK);
    chk("d1_e1_dom",  8'(bus2.DOM_RST_N), 8'h01);
    chk("d1_e1_done", 8'(bus2.SEQ_DONE),  8'h01);
    chk("d1_e1_busy", 8'(bus2.SEQ_BUSY),  8'h00);
    #1 bus2.SW_RST_REQ = 1'b1; bus2.SW_RST_MASK = 1'b1;
    @(negedge CLK);
    chk("d1_ack",      8'(bus2.SW_RST_ACK), 8'h01);
    chk("d1_ack_dom",  8'(bus2.DOM_RST_N),  8'h00);
    chk("d1_ack_busy", 8'(bus2.SEQ_BUSY),   8'h01);
    @(negedge CLK);
    chk("d1_rel_ack",  8'(bus2.SW_RST_ACK), 8'h00);
    chk("d1_rel_dom",  8'(bus2.DOM_RST_N),  8'h01);
    chk("d1_rel_done", 8'(bus2.SEQ_DONE),   8'h01);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
